pixel_tracker: RTL and testbench

- Receive-side counterpart of the display timing generator.
- Consumes an incoming hs/vs/de stream, recovers the active-pixel x/y coordinate of each pixel, and checks frame geometry against expected dimensions.
- Reports lock status.
- Sits after a video input or loopback and feeds capture/overlay logic running on the same pixel clock.

---
 rtl/pixel_tracker_if.sv | 26 ++
 rtl/pixel_tracker.sv | 232 +++++++++++++++++++++++
 tb/tb_pixel_tracker.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_tracker_if.sv
// Video stream bundle for pixel_tracker: incoming hs/vs/de plus the recovered
// pixel coordinate and lock status. The master side produces the sync
// stream. The slave side is the tracker, which produces coordinates and status.
interface pixel_tracker_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9
);
    logic               hs;
    logic               vs;
    logic               de;
    logic               pix_valid;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic               locked;
    logic               lock_lost;

    modport master (
        output hs, vs, de,
        input  pix_valid, x, y, locked, lock_lost
    );

    modport slave (
        input  hs, vs, de,
        output pix_valid, x, y, locked, lock_lost
    );
endinterface

// File: rtl/pixel_tracker.sv
// pixel_tracker: receive-side video timing recovery.
// Recovers the active-pixel x/y of every de=1 pixel one cycle after it is
// sampled. It also checks each frame's geometry (de run length and run count)
// against HOR_ACTIVE_PIXELS x VER_ACTIVE_PIXELS and locks after LOCK_FRAMES
// consecutive good frames.
// Optional macro PIXEL_TRACKER_MEASURE_EN adds the h_total/v_total
// measurement outputs. hs is used only by that feature.
module pixel_tracker #(
    parameter int  HOR_ACTIVE_PIXELS = 640,
    parameter int  VER_ACTIVE_PIXELS = 480,
    parameter int  LOCK_FRAMES       = 3,
    localparam int X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic          clk_rgb,
    input  logic          rst,
    pixel_tracker_if.slave vid
`ifdef PIXEL_TRACKER_MEASURE_EN
    ,
    output logic [15:0]   h_total,
    output logic [15:0]   v_total
`endif
);

    localparam int LEN_W = $clog2(HOR_ACTIVE_PIXELS + 2);
    localparam int RUN_W = $clog2(VER_ACTIVE_PIXELS + 2);
    localparam int CNT_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [X_WIDTH-1:0] X_MAX      = X_WIDTH'(HOR_ACTIVE_PIXELS - 1);
    localparam logic [Y_WIDTH-1:0] Y_MAX      = Y_WIDTH'(VER_ACTIVE_PIXELS - 1);
    localparam logic [LEN_W-1:0]   LEN_FULL   = LEN_W'(HOR_ACTIVE_PIXELS);
    localparam logic [LEN_W-1:0]   LEN_SAT    = LEN_W'(HOR_ACTIVE_PIXELS + 1);
    localparam logic [RUN_W-1:0]   RUN_FULL   = RUN_W'(VER_ACTIVE_PIXELS);
    localparam logic [RUN_W-1:0]   RUN_SAT    = RUN_W'(VER_ACTIVE_PIXELS + 1);
    localparam logic [RUN_W:0]     RUNS_GOOD  = (RUN_W + 1)'(VER_ACTIVE_PIXELS);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   good_cnt_q;
    logic               locked_q;
    logic               lock_lost_q;

    logic               vs_d_q;
    logic               de_d_q;
    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q;
    logic               pix_valid_q;
    logic [LEN_W-1:0]   len_q;
    logic [RUN_W-1:0]   run_cnt_q;
    logic               bad_q;

    logic               vs_rise;
    logic               de_rise;
    logic               de_fall;
    logic               de_merge;
    logic               run_start;
    logic               x_sat;
    logic               y_over;
    logic               line_bad;
    logic [RUN_W:0]     runs_closed;
    logic               frame_good;
    logic [Y_WIDTH-1:0] y_line;

    assign vs_rise   = vid.vs & ~vs_d_q;
    assign de_rise   = vid.de & ~de_d_q;
    assign de_fall   = ~vid.de & de_d_q;
    // de still high when the frame boundary arrives: the line is cut in two.
    assign de_merge  = vs_rise & vid.de & de_d_q;
    // A run (and x) restarts at de_rise, or at a frame boundary with de high.
    assign run_start = vid.de & (~de_d_q | vs_rise);

    assign x_sat     = vid.de & ~run_start & (x_q == X_MAX);
    assign y_over    = de_rise & ~vs_rise & (run_cnt_q >= RUN_FULL);
    assign line_bad  = de_fall & (len_q != LEN_FULL);
    assign y_line    = (run_cnt_q >= RUN_FULL) ? Y_MAX : Y_WIDTH'(run_cnt_q);

    // A line ending exactly on vs_rise still belongs to the closing frame.
    assign runs_closed = {1'b0, run_cnt_q} + {{RUN_W{1'b0}}, de_fall};
    assign frame_good  = ~bad_q & ~line_bad & ~de_merge & (runs_closed == RUNS_GOOD);

    // Edge history, coordinate recovery and per-frame geometry accumulation.
    always_ff @(posedge clk_rgb) begin
        if (!rst) begin
            vs_d_q      <= 1'b0;
            de_d_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pix_valid_q <= 1'b0;
            len_q       <= '0;
            run_cnt_q   <= '0;
            bad_q       <= 1'b0;
        end else begin
            vs_d_q      <= vid.vs;
            de_d_q      <= vid.de;
            pix_valid_q <= vid.de & ((state_q != SEARCH) | vs_rise);

            if (vid.de) begin
                if (run_start) begin
                    x_q   <= '0;
                    len_q <= LEN_W'(1);
                end else begin
                    if (x_q != X_MAX) x_q <= x_q + X_WIDTH'(1);
                    if (len_q != LEN_SAT) len_q <= len_q + LEN_W'(1);
                end
                if (vs_rise) begin
                    y_q <= '0;
                end else if (de_rise) begin
                    y_q <= y_line;
                end
            end

            if (vs_rise) begin
                run_cnt_q <= '0;
                bad_q     <= 1'b0;
            end else begin
                if (de_fall && (run_cnt_q != RUN_SAT)) run_cnt_q <= run_cnt_q + RUN_W'(1);
                if (x_sat || y_over || line_bad) bad_q <= 1'b1;
            end
        end
    end

    // Lock FSM, advanced only at frame boundaries (vs_rise).
    always_ff @(posedge clk_rgb) begin
        if (!rst) begin
            state_q     <= SEARCH;
            good_cnt_q  <= '0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            lock_lost_q <= 1'b0;
            if (vs_rise) begin
                case (state_q)
                    SEARCH: begin
                        state_q    <= ACQUIRE;
                        good_cnt_q <= '0;
                    end
                    ACQUIRE: begin
                        if (frame_good) begin
                            if (good_cnt_q == CNT_LAST) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                good_cnt_q <= '0;
                            end else begin
                                good_cnt_q <= good_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            good_cnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!frame_good) begin
                            state_q     <= ACQUIRE;
                            locked_q    <= 1'b0;
                            lock_lost_q <= 1'b1;
                            good_cnt_q  <= '0;
                        end
                    end
                    default: begin
                        state_q    <= SEARCH;
                        locked_q   <= 1'b0;
                        good_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign vid.pix_valid = pix_valid_q;
    assign vid.x         = x_q;
    assign vid.y         = y_q;
    assign vid.locked    = locked_q;
    assign vid.lock_lost = lock_lost_q;

`ifdef PIXEL_TRACKER_MEASURE_EN
    logic        hs_d_q;
    logic        hs_rise;
    logic [15:0] h_cnt_q;
    logic [15:0] v_cnt_q;
    logic        h_seen_q;
    logic        v_seen_q;
    logic [15:0] h_total_q;
    logic [15:0] v_total_q;

    assign hs_rise = vid.hs & ~hs_d_q;

    // Line period in clocks and frame period in hs edges; a total is only
    // published once a full interval has been observed since reset.
    always_ff @(posedge clk_rgb) begin
        if (!rst) begin
            hs_d_q    <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_seen_q  <= 1'b0;
            v_seen_q  <= 1'b0;
            h_total_q <= '0;
            v_total_q <= '0;
        end else begin
            hs_d_q <= vid.hs;

            if (hs_rise) begin
                h_cnt_q  <= 16'd1;
                h_seen_q <= 1'b1;
                if (h_seen_q) h_total_q <= h_cnt_q;
            end else if (h_cnt_q != 16'hFFFF) begin
                h_cnt_q <= h_cnt_q + 16'd1;
            end

            if (vs_rise) begin
                v_cnt_q  <= {15'd0, hs_rise};
                v_seen_q <= 1'b1;
                if (v_seen_q) v_total_q <= v_cnt_q;
            end else if (hs_rise && (v_cnt_q != 16'hFFFF)) begin
                v_cnt_q <= v_cnt_q + 16'd1;
            end
        end
    end

    assign h_total = h_total_q;
    assign v_total = v_total_q;
`else
    // hs only feeds the measurement logic, which is absent in this build.
    logic unused_hs;
    assign unused_hs = vid.hs;
`endif

endmodule

// File: tb/tb_pixel_tracker.sv
// Directed bench for pixel_tracker with an 8x4 active area, lock after
// 2 good frames, 12 clocks/line, 7 lines/frame, active at h 2..9, lines 1..4.
// Define PIXEL_TRACKER_MEASURE_EN to also exercise h_total/v_total.
module tb_pixel_tracker;

    logic clk_rgb = 1'b0;
    logic rst     = 1'b0;

    always #5 clk_rgb = ~clk_rgb;

    pixel_tracker_if #(.X_WIDTH(3), .Y_WIDTH(2)) vif ();

`ifdef PIXEL_TRACKER_MEASURE_EN
    logic [15:0] h_total;
    logic [15:0] v_total;
`endif

    pixel_tracker #(
        .HOR_ACTIVE_PIXELS(8),
        .VER_ACTIVE_PIXELS(4),
        .LOCK_FRAMES(2)
    ) dut (
        .clk_rgb(clk_rgb),
        .rst(rst),
        .vid(vif)
`ifdef PIXEL_TRACKER_MEASURE_EN
        ,
        .h_total(h_total),
        .v_total(v_total)
`endif
    );

    int   tests_run    = 0;
    int   tests_failed = 0;

    // Per-frame observations gathered by drive_frame.
    int   n_valid;
    int   pix_err;
    int   first_x, first_y, last_x, last_y;
    logic locked_at_vs, lost_at_vs, lost_after_vs, locked_end;

    task automatic step(input logic h, input logic v, input logic d);
        vif.hs = h;
        vif.vs = v;
        vif.de = d;
        @(posedge clk_rgb);
        #1;
    endtask

    // One frame of the stream. act_lines active lines (1..act_lines), line
    // long_line gets a 9-pixel de run, cut_tail ends the frame right after
    // the last pixel of line act_lines, start_line>0 skips the frame start.
    task automatic drive_frame(input int act_lines, input int long_line,
                               input bit cut_tail, input int start_line);
        bit         done = 0;
        logic       d;
        int         de_end;
        int         exp_x, exp_y;
        logic [2:0] ex;
        logic [1:0] ey;
        n_valid = 0;
        pix_err = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        for (int L = start_line; L < 7 && !done; L++) begin
            for (int h = 0; h < 12 && !done; h++) begin
                if (cut_tail && L == act_lines && h == 10) begin
                    done = 1;
                end else begin
                    de_end = (L == long_line) ? 10 : 9;
                    d = (L >= 1 && L <= act_lines && h >= 2 && h <= de_end);
                    step(h < 2, L == 0, d);
                    if (L == 0 && h == 0) begin
                        locked_at_vs = vif.locked;
                        lost_at_vs   = vif.lock_lost;
                    end
                    if (L == 0 && h == 1) lost_after_vs = vif.lock_lost;
                    locked_end = vif.locked;
                    if (vif.pix_valid === 1'b1) begin
                        exp_x = (h - 2 > 7) ? 7 : h - 2;
                        exp_y = (L - 1 > 3) ? 3 : L - 1;
                        ex = 3'(exp_x);
                        ey = 2'(exp_y);
                        n_valid++;
                        if (!d || vif.x !== ex || vif.y !== ey) pix_err++;
                        if (n_valid == 1) begin
                            first_x = int'(vif.x);
                            first_y = int'(vif.y);
                        end
                        last_x = int'(vif.x);
                        last_y = int'(vif.y);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [2:0] hv [3];
        hv[0] = 3'b111; hv[1] = 3'b001; hv[2] = 3'b110;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(hv[i][2], hv[i][1], hv[i][0]);
            tests_run++;
            if ({vif.pix_valid, vif.x, vif.y, vif.locked, vif.lock_lost} !== 8'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got pv=%b x=%0d y=%0d lk=%b ll=%b required all 0",
                         i, vif.pix_valid, vif.x, vif.y, vif.locked, vif.lock_lost);
            end
        end
`ifdef PIXEL_TRACKER_MEASURE_EN
        tests_run++;
        if (h_total !== 16'd0 || v_total !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_totals: got h=%0d v=%0d required 0 0", h_total, v_total);
        end
`endif
        rst = 1'b1;
        drive_frame(4, -1, 0, 3);
        tests_run++;
        if (n_valid !== 0) begin
            tests_failed++;
            $display("FAIL search_no_valid: got %0d valid pixels required 0", n_valid);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_clean();
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (n_valid !== 32 || pix_err !== 0) begin
            tests_failed++;
            $display("FAIL clean_pixels: got %0d valid, %0d bad required 32 valid, 0 bad", n_valid, pix_err);
        end
        tests_run++;
        if (first_x !== 0 || first_y !== 0 || last_x !== 7 || last_y !== 3) begin
            tests_failed++;
            $display("FAIL clean_corners: got first (%0d,%0d) last (%0d,%0d) required (0,0) (7,3)",
                     first_x, first_y, last_x, last_y);
        end
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (locked_at_vs !== 1'b0 || locked_end !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_lock: got locked %b/%b required 0/0", locked_at_vs, locked_end);
        end
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (locked_at_vs !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_3rd_vs: got locked=%b required 1", locked_at_vs);
        end
        $display("[TB] clean stream: locked=%b", locked_at_vs);
    endtask

    task automatic test_x_saturation();
        drive_frame(4, 2, 0, 0);
        tests_run++;
        if (n_valid !== 33 || pix_err !== 0 || locked_end !== 1'b1) begin
            tests_failed++;
            $display("FAIL x_sat_pixels: got %0d valid, %0d bad, locked=%b required 33, 0, 1",
                     n_valid, pix_err, locked_end);
        end
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (lost_at_vs !== 1'b1 || locked_at_vs !== 1'b0 || lost_after_vs !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_lost_pulse: got lost=%b locked=%b lost_next=%b required 1 0 0",
                     lost_at_vs, locked_at_vs, lost_after_vs);
        end
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (locked_at_vs !== 1'b0) begin
            tests_failed++;
            $display("FAIL relock_early: got locked=%b required 0", locked_at_vs);
        end
        $display("[TB] x saturation: lock_lost seen");
    endtask

    task automatic test_y_saturation();
        drive_frame(5, -1, 0, 0);
        tests_run++;
        if (locked_at_vs !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock: got locked=%b required 1", locked_at_vs);
        end
        tests_run++;
        if (n_valid !== 40 || pix_err !== 0 || last_y !== 3) begin
            tests_failed++;
            $display("FAIL y_sat_pixels: got %0d valid, %0d bad, last_y=%0d required 40, 0, 3",
                     n_valid, pix_err, last_y);
        end
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (lost_at_vs !== 1'b1) begin
            tests_failed++;
            $display("FAIL y_sat_bad_frame: got lock_lost=%b required 1", lost_at_vs);
        end
        drive_frame(5, -1, 0, 0);
        drive_frame(4, -1, 0, 0);
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (locked_at_vs !== 1'b0) begin
            tests_failed++;
            $display("FAIL good_cnt_reset: got locked=%b required 0", locked_at_vs);
        end
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (locked_at_vs !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock_after_bad: got locked=%b required 1", locked_at_vs);
        end
        $display("[TB] y saturation: frame rejected, relocked");
    endtask

    task automatic test_coincident_edges();
        drive_frame(4, -1, 1, 0);
        tests_run++;
        if (n_valid !== 32 || pix_err !== 0) begin
            tests_failed++;
            $display("FAIL cut_frame_pixels: got %0d valid, %0d bad required 32, 0", n_valid, pix_err);
        end
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (lost_at_vs !== 1'b0 || locked_at_vs !== 1'b1) begin
            tests_failed++;
            $display("FAIL coincident_good: got lost=%b locked=%b required 0 1", lost_at_vs, locked_at_vs);
        end
        tests_run++;
        if (first_x !== 0 || first_y !== 0 || pix_err !== 0) begin
            tests_failed++;
            $display("FAIL new_frame_origin: got (%0d,%0d) bad=%0d required (0,0) 0", first_x, first_y, pix_err);
        end
        $display("[TB] coincident de_fall/vs_rise handled");
    endtask

    task automatic test_midframe_reset();
        drive_frame(2, -1, 1, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        tests_run++;
        if (vif.locked !== 1'b0 || vif.lock_lost !== 1'b0 || vif.pix_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_reset: got lk=%b ll=%b pv=%b required 0 0 0",
                     vif.locked, vif.lock_lost, vif.pix_valid);
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (vif.lock_lost !== 1'b0 || vif.locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_pulse: got ll=%b lk=%b required 0 0", vif.lock_lost, vif.locked);
        end
        $display("[TB] mid-frame reset done");
    endtask

`ifdef PIXEL_TRACKER_MEASURE_EN
    task automatic test_measure();
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (h_total !== 16'd12 || v_total !== 16'd0) begin
            tests_failed++;
            $display("FAIL measure_first: got h=%0d v=%0d required 12 0", h_total, v_total);
        end
        drive_frame(4, -1, 0, 0);
        tests_run++;
        if (h_total !== 16'd12 || v_total !== 16'd7) begin
            tests_failed++;
            $display("FAIL measure_second: got h=%0d v=%0d required 12 7", h_total, v_total);
        end
        $display("[TB] measure h_total=%0d v_total=%0d", h_total, v_total);
    endtask
`endif

    initial begin
        vif.hs = 1'b0;
        vif.vs = 1'b0;
        vif.de = 1'b0;
        test_reset();
        test_clean();
        test_x_saturation();
        test_y_saturation();
        test_coincident_edges();
        test_midframe_reset();
`ifdef PIXEL_TRACKER_MEASURE_EN
        test_measure();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
